// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// Snoops the core writeback port and stores timestamped records
// {addr, data, stamp} in a FIFO drained through a show-ahead
// valid/ready port. Supports stop-on-full and keep-latest (wrap) modes.
module wb_trace_buffer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    parameter int SKIP_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       enable,
    input  logic                       wrap_mode,
    input  logic                       clear,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [STAMP_W-1:0]         rd_stamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = ADDR_W + DATA_W + STAMP_W;

    logic [STAMP_W-1:0] stamp;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [REC_W-1:0]   head;

    logic               is_r0;
    logic               cap;
    logic               pop;
    logic               push;
    logic               adv_rd;
    logic               lost;
    logic [CNT_W-1:0]   count_nxt;

    // Qualify the writeback strobe and decide what happens to the FIFO this cycle.
    always_comb begin
        is_r0     = (SKIP_R0 != 0) && (wb_addr == '0);
        cap       = wb_valid & enable & ~is_r0;
        pop       = rd_valid & rd_ready;
        push      = 1'b0;
        adv_rd    = 1'b0;
        lost      = 1'b0;
        count_nxt = count;
        if (!clear) begin
            // A full FIFO still accepts a capture when the head leaves this
            // cycle, or when wrap mode lets the newest record evict the oldest.
            push   = cap & (~full | pop | wrap_mode);
            adv_rd = pop | (cap & full & wrap_mode);
            lost   = cap & full & ~pop;
            if (push && !adv_rd) begin
                count_nxt = count + CNT_W'(1);
            end else if (adv_rd && !push) begin
                count_nxt = count - CNT_W'(1);
            end
        end
    end

    // Free-running cycle stamp; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
        end
    end

    // Record storage; contents need no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {wb_addr, wb_data, stamp};
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
            if (lost) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Show-ahead head record, forced to zero while nothing is stored.
    always_comb begin
        rd_valid = ~empty;
        head     = mem[rd_ptr];
        if (rd_valid) begin
            {rd_addr, rd_data, rd_stamp} = head;
        end else begin
            rd_addr  = '0;
            rd_data  = '0;
            rd_stamp = '0;
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Testbench for wb_trace_buffer (DEPTH=4): directed scenarios followed by
// randomized traffic, all checked each cycle against a queue-based model.
module tb_wb_trace_buffer;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 4;
    localparam int STAMP_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  d;
        logic [STAMP_W-1:0] s;
    } rec_t;

    logic               clk;
    logic               rst;
    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               enable;
    logic               wrap_mode;
    logic               clear;
    logic               rd_valid;
    logic               rd_ready;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic [STAMP_W-1:0] rd_stamp;
    logic [2:0]         count;
    logic               full;
    logic               empty;
    logic               overflow;
    logic [15:0]        drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    rec_t               q[$];
    logic [STAMP_W-1:0] m_stamp = '0;
    logic               m_ovf   = 1'b0;
    logic [15:0]        m_drops = '0;

    wb_trace_buffer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .STAMP_W(STAMP_W), .SKIP_R0(1)
    ) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .enable(enable), .wrap_mode(wrap_mode),
        .clear(clear), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_stamp(rd_stamp),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Model one clock edge from the rules: pop first, then capture into
    // whatever room is left, evicting the oldest in wrap mode.
    task automatic model_edge();
        bit capv, popv;
        rec_t r;
        if (rst) begin
            q.delete();
            m_stamp = '0;
            m_ovf   = 1'b0;
            m_drops = '0;
            return;
        end
        capv = wb_valid && enable && (wb_addr != 0);
        popv = (q.size() > 0) && rd_ready;
        r.a = wb_addr;
        r.d = wb_data;
        r.s = m_stamp;
        if (clear) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = '0;
        end else begin
            if (popv) void'(q.pop_front());
            if (capv) begin
                if (q.size() < DEPTH) begin
                    q.push_back(r);
                end else begin
                    if (wrap_mode) begin
                        void'(q.pop_front());
                        q.push_back(r);
                    end
                    m_ovf = 1'b1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
            end
        end
        m_stamp = m_stamp + 16'd1;
    endtask

    task automatic compare_all();
        rec_t h;
        h = '0;
        if (q.size() > 0) h = q[0];
        check_val("rd_valid",   rd_valid,   q.size() > 0);
        check_val("rd_addr",    rd_addr,    h.a);
        check_val("rd_data",    rd_data,    h.d);
        check_val("rd_stamp",   rd_stamp,   h.s);
        check_val("count",      count,      q.size());
        check_val("full",       full,       q.size() == DEPTH);
        check_val("empty",      empty,      q.size() == 0);
        check_val("overflow",   overflow,   m_ovf);
        check_val("drop_count", drop_count, m_drops);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cap_tick(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] last_d;
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        enable = 1'b1; wrap_mode = 1'b0; clear = 1'b0; rd_ready = 1'b0;

        // reset values
        tick();
        check_val("rst_empty", empty, 1);
        check_val("rst_rd_valid", rd_valid, 0);
        rst = 1'b0;

        // basic capture on cycles 2 and 3
        tick();
        tick();
        cap_tick(4'd3, 32'h11);
        check_val("basic_addr0", rd_addr, 3);
        check_val("basic_data0", rd_data, 32'h11);
        check_val("basic_stamp0", rd_stamp, 2);
        check_val("basic_cnt1", count, 1);
        cap_tick(4'd5, 32'h22);
        check_val("basic_cnt2", count, 2);
        check_val("basic_hold", rd_data, 32'h11);
        rd_ready = 1'b1;
        tick();
        check_val("basic_addr1", rd_addr, 5);
        check_val("basic_data1", rd_data, 32'h22);
        check_val("basic_stamp1", rd_stamp, 3);
        tick();
        rd_ready = 1'b0;
        check_val("basic_drained", empty, 1);

        // R0 filter and enable gating
        cap_tick(4'd0, 32'hAA);
        enable = 1'b0;
        cap_tick(4'd7, 32'hBB);
        enable = 1'b1;
        check_val("filt_empty", empty, 1);
        check_val("filt_drops", drop_count, 0);

        // stop-on-full
        wrap_mode = 1'b0;
        for (int i = 1; i <= 6; i++) cap_tick(4'd1, DATA_W'(i));
        check_val("sof_count", count, 4);
        check_val("sof_full", full, 1);
        check_val("sof_ovf", overflow, 1);
        check_val("sof_drops", drop_count, 2);
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_val("sof_drain", rd_data, DATA_W'(i));
            tick();
        end
        rd_ready = 1'b0;
        do_clear();

        // wrap mode keeps the latest
        wrap_mode = 1'b1;
        for (int i = 1; i <= 6; i++) cap_tick(4'd2, DATA_W'(i));
        check_val("wrap_drops", drop_count, 2);
        check_val("wrap_ovf", overflow, 1);
        rd_ready = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            check_val("wrap_drain", rd_data, DATA_W'(i));
            tick();
        end
        rd_ready = 1'b0;
        wrap_mode = 1'b0;
        do_clear();

        // simultaneous push and pop while full
        for (int i = 0; i < 4; i++) cap_tick(4'd4, DATA_W'(32'h10 + i));
        rd_ready = 1'b1;
        cap_tick(4'd4, 32'h9);
        check_val("pp_count", count, 4);
        check_val("pp_ovf", overflow, 0);
        last_d = '0;
        for (int i = 0; i < 4; i++) begin
            last_d = rd_data;
            tick();
        end
        check_val("pp_last", last_d, 32'h9);
        rd_ready = 1'b0;

        // clear together with a capture, then reset mid-stream
        cap_tick(4'd6, 32'h61);
        cap_tick(4'd6, 32'h62);
        clear = 1'b1;
        cap_tick(4'd6, 32'h63);
        clear = 1'b0;
        check_val("clr_empty", empty, 1);
        check_val("clr_count", count, 0);
        check_val("clr_ovf", overflow, 0);
        cap_tick(4'd6, 32'h64);
        check_val("clr_stamp_runs", rd_stamp != 0, 1);
        cap_tick(4'd6, 32'h65);
        rst = 1'b1;
        cap_tick(4'd6, 32'h66);
        rst = 1'b0;
        check_val("mrst_empty", empty, 1);
        check_val("mrst_count", count, 0);
        cap_tick(4'd8, 32'h77);
        check_val("mrst_stamp0", rd_stamp, 0);
        check_val("mrst_data", rd_data, 32'h77);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_addr  = ADDR_W'($urandom_range(0, 15));
            wb_data  = $urandom;
            enable   = ($urandom_range(0, 9) != 0);
            rd_ready = ($urandom_range(0, 9) < 4);
            clear    = ($urandom_range(0, 99) < 2);
            rst      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) wrap_mode = ~wrap_mode;
            tick();
        end
        rst = 1'b0; clear = 1'b0; wb_valid = 1'b0; rd_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
